// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, mem_arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   logic        busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_we, m_addr, m_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_we, m_addr, m_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-cycle shared memory, one access per 2 cycles.
// Optional macro MEM_ARBITER_RR_EN selects round-robin ties instead of data-priority with fetch anti-starvation.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACC  = 1'b1;

   logic [0:0]  state_r;
   logic        id_data_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        i_rvalid_r;
   logic        d_rvalid_r;
   logic [31:0] i_rdata_r;
   logic [31:0] d_rdata_r;
   logic        data_wins_s;
   logic        i_gnt_s;
   logic        d_gnt_s;

`ifdef MEM_ARBITER_RR_EN
   logic last_data_r;

   // tie-break: whichever port was not granted last wins
   always_comb begin
      if (bus.i_req && bus.d_req) begin
         data_wins_s = ~last_data_r;
      end else begin
         data_wins_s = bus.d_req;
      end
   end

   // remember the most recent winner; reset value favours data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_data_r <= 1'b0;
      end else if (d_gnt_s) begin
         last_data_r <= 1'b1;
      end else if (i_gnt_s) begin
         last_data_r <= 1'b0;
      end else begin
         last_data_r <= last_data_r;
      end
   end
`else
   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
   logic [3:0] starve_r;

   // data wins a tie unless fetch has lost LIMIT_C times in a row
   always_comb begin
      if (bus.i_req && bus.d_req) begin
         data_wins_s = (starve_r != LIMIT_C);
      end else begin
         data_wins_s = bus.d_req;
      end
   end

   // count fetch losses, saturating; any fetch grant clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_r <= 4'd0;
      end else if (i_gnt_s) begin
         starve_r <= 4'd0;
      end else if (bus.i_req && d_gnt_s && (starve_r != LIMIT_C)) begin
         starve_r <= starve_r + 4'd1;
      end else begin
         starve_r <= starve_r;
      end
   end
`endif

   // grants are combinational and only possible in IDLE outside reset
   always_comb begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if ((state_r == ST_IDLE) && rst) begin
         d_gnt_s = data_wins_s;
         i_gnt_s = ~data_wins_s & bus.i_req;
      end else begin
         i_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end
   end

   // access sequencer: latch winner in IDLE, complete and clear latches in ACC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         id_data_r  <= 1'b0;
         we_r       <= 1'b0;
         addr_r     <= 32'h0;
         wdata_r    <= 32'h0;
         i_rvalid_r <= 1'b0;
         d_rvalid_r <= 1'b0;
         i_rdata_r  <= 32'h0;
         d_rdata_r  <= 32'h0;
      end else begin
         i_rvalid_r <= 1'b0;
         d_rvalid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_gnt_s || d_gnt_s) begin
                  state_r   <= ST_ACC;
                  id_data_r <= d_gnt_s;
                  we_r      <= d_gnt_s & bus.d_we;
                  addr_r    <= d_gnt_s ? bus.d_addr : bus.i_addr;
                  wdata_r   <= d_gnt_s ? bus.d_wdata : 32'h0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACC: begin
               state_r   <= ST_IDLE;
               id_data_r <= 1'b0;
               we_r      <= 1'b0;
               addr_r    <= 32'h0;
               wdata_r   <= 32'h0;
               if (id_data_r) begin
                  d_rvalid_r <= 1'b1;
                  // writes only acknowledge; d_rdata keeps the last read value
                  if (!we_r) begin
                     d_rdata_r <= bus.m_rdata;
                  end else begin
                     d_rdata_r <= d_rdata_r;
                  end
               end else begin
                  i_rvalid_r <= 1'b1;
                  i_rdata_r  <= bus.m_rdata;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.i_gnt    = i_gnt_s;
   assign bus.d_gnt    = d_gnt_s;
   assign bus.i_rvalid = i_rvalid_r;
   assign bus.d_rvalid = d_rvalid_r;
   assign bus.i_rdata  = i_rdata_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.m_we     = we_r;
   assign bus.m_addr   = addr_r;
   assign bus.m_wdata  = wdata_r;
   assign bus.busy     = (state_r == ST_ACC);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level reference model and a reference memory image.
module tb_mem_arbiter;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   logic load_mem;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] env_mem [0:255];
   logic [31:0] ref_mem [0:255];

   assign bus.m_rdata = env_mem[bus.m_addr[7:0]];

   // environment memory: preload from the reference image, then follow m_we
   always @(posedge clk) begin
      if (load_mem) begin
         for (int k = 0; k < 256; k++) env_mem[k] <= ref_mem[k];
      end else if (bus.m_we) begin
         env_mem[bus.m_addr[7:0]] <= bus.m_wdata;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   // reference model state (transaction level)
   bit          m_acc, p_data, p_we, last_data;
   logic [31:0] p_addr, p_wdata;
   int          starve;
   bit          e_i_rvalid, e_d_rvalid;
   logic [31:0] e_i_rdata, e_d_rdata;

   bit hold_i, hold_d, rand_mode;
   bit obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid, obs_busy;
   logic [31:0] obs_i_rdata, obs_d_rdata;
   int we_pulses, drv_pulses;
   bit gseq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_i_gnt"}, bus.i_gnt, 32'h0);
      chk({tag, "_d_gnt"}, bus.d_gnt, 32'h0);
      chk({tag, "_i_rvalid"}, bus.i_rvalid, 32'h0);
      chk({tag, "_d_rvalid"}, bus.d_rvalid, 32'h0);
      chk({tag, "_i_rdata"}, bus.i_rdata, 32'h0);
      chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
      chk({tag, "_m_we"}, bus.m_we, 32'h0);
      chk({tag, "_m_addr"}, bus.m_addr, 32'h0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 32'h0);
      chk({tag, "_busy"}, bus.busy, 32'h0);
   endtask

   task automatic model_reset();
      m_acc = 1'b0; p_data = 1'b0; p_we = 1'b0; last_data = 1'b0;
      p_addr = 32'h0; p_wdata = 32'h0; starve = 0;
      e_i_rvalid = 1'b0; e_d_rvalid = 1'b0;
      e_i_rdata = 32'h0; e_d_rdata = 32'h0;
   endtask

   // one clock cycle: predict, compare at negedge, advance model, drive next inputs
   task automatic run_cycle();
      bit ei, ed, tie;
      @(negedge clk);
      ei = 1'b0;
      ed = 1'b0;
      tie = bus.i_req && bus.d_req;
      if (!m_acc) begin
`ifdef MEM_ARBITER_RR_EN
         if (tie) begin
            ed = !last_data;
            ei = last_data;
         end
`else
         if (tie) begin
            ei = (starve == LIMIT);
            ed = !ei;
         end
`endif
         else begin
            ei = bus.i_req;
            ed = bus.d_req;
         end
      end

      chk("i_gnt", bus.i_gnt, ei);
      chk("d_gnt", bus.d_gnt, ed);
      chk("busy", bus.busy, m_acc);
      chk("i_rvalid", bus.i_rvalid, e_i_rvalid);
      chk("d_rvalid", bus.d_rvalid, e_d_rvalid);
      chk("i_rdata", bus.i_rdata, e_i_rdata);
      chk("d_rdata", bus.d_rdata, e_d_rdata);
      chk("m_we", bus.m_we, m_acc && p_data && p_we);
      chk("m_addr", bus.m_addr, m_acc ? p_addr : 32'h0);
      if (!m_acc || p_data) chk("m_wdata", bus.m_wdata, m_acc ? p_wdata : 32'h0);

      obs_i_gnt = bus.i_gnt; obs_d_gnt = bus.d_gnt; obs_busy = bus.busy;
      obs_i_rvalid = bus.i_rvalid; obs_d_rvalid = bus.d_rvalid;
      obs_i_rdata = bus.i_rdata; obs_d_rdata = bus.d_rdata;
      if (bus.m_we) we_pulses++;
      if (bus.d_rvalid) drv_pulses++;
      if (bus.d_gnt) gseq.push_back(1'b1);
      else if (bus.i_gnt) gseq.push_back(1'b0);

      e_i_rvalid = 1'b0;
      e_d_rvalid = 1'b0;
      if (m_acc) begin
         if (p_data) begin
            if (p_we) ref_mem[p_addr[7:0]] = p_wdata;
            else e_d_rdata = ref_mem[p_addr[7:0]];
            e_d_rvalid = 1'b1;
         end else begin
            e_i_rdata = ref_mem[p_addr[7:0]];
            e_i_rvalid = 1'b1;
         end
         m_acc = 1'b0;
      end else begin
`ifdef MEM_ARBITER_RR_EN
         if (ed) last_data = 1'b1;
         else if (ei) last_data = 1'b0;
`else
         if (ei) starve = 0;
         else if (bus.i_req && ed && starve < LIMIT) starve++;
`endif
         if (ei || ed) begin
            m_acc = 1'b1;
            p_data = ed;
            p_we = ed && bus.d_we;
            p_addr = ed ? bus.d_addr : bus.i_addr;
            p_wdata = bus.d_wdata;
         end
      end

      @(posedge clk);
      #1;
      if (ei) begin
         if (hold_i) bus.i_addr = 32'($urandom_range(0, 255));
         else bus.i_req = 1'b0;
      end
      if (ed) begin
         if (hold_d) bus.d_addr = 32'($urandom_range(0, 255));
         else bus.d_req = 1'b0;
      end
      if (rand_mode) begin
         if (!bus.i_req && ($urandom_range(0, 1) == 1)) begin
            bus.i_req = 1'b1;
            bus.i_addr = 32'($urandom_range(0, 255));
         end
         if (!bus.d_req && ($urandom_range(0, 1) == 1)) begin
            bus.d_req = 1'b1;
            bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = 32'($urandom_range(0, 255));
            bus.d_wdata = $urandom;
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      load_mem = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      hold_i = 1'b0; hold_d = 1'b0; rand_mode = 1'b0;
      we_pulses = 0; drv_pulses = 0;
      for (int k = 0; k < 256; k++) ref_mem[k] = $urandom;
      ref_mem[8'h10] = 32'hDEADBEEF;
      ref_mem[8'h80] = 32'h0;
      model_reset();

      @(posedge clk); #1;
      check_zero("reset");
      @(posedge clk); #1;
      load_mem = 1'b0;
      rst = 1'b1;

      // fetch-only read
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      run_cycle(); chk("r030_gnt", obs_i_gnt, 32'h1);
      run_cycle(); chk("r030_busy", obs_busy, 32'h1);
      run_cycle(); chk("r030_rvalid", obs_i_rvalid, 32'h1);
      chk("r030_rdata", obs_i_rdata, 32'hDEADBEEF);

      // data write then read back
      we_pulses = 0; drv_pulses = 0;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
      repeat (3) run_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
      repeat (3) run_cycle();
      chk("r031_we_pulses", 32'(we_pulses), 32'd1);
      chk("r031_rvalid_pulses", 32'(drv_pulses), 32'd2);
      chk("r031_rdata", obs_d_rdata, 32'h12345678);

      // data request rising during a fetch access
      bus.i_req = 1'b1; bus.i_addr = 32'h20;
      run_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h24;
      run_cycle(); chk("r035_acc_no_dgnt", obs_d_gnt, 32'h0);
      run_cycle(); chk("r035_dgnt", obs_d_gnt, 32'h1);
      chk("r035_i_rvalid", obs_i_rvalid, 32'h1);
      repeat (2) run_cycle();

      // reset in the middle of a write access
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hA5A5A5A5;
      run_cycle();
      chk("r034_m_we_acc", bus.m_we, 32'h1);
      #2 rst = 1'b0;
      #1 check_zero("r034_now");
      @(posedge clk); #1;
      check_zero("r034_edge");
      chk("r034_mem", env_mem[8'h80], 32'h0);
      rst = 1'b1;
      model_reset();

      // both ports hold requests continuously
      hold_i = 1'b1; hold_d = 1'b1;
      bus.i_req = 1'b1; bus.i_addr = 32'h30;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h34;
      gseq.delete();
      repeat (20) run_cycle();
      chk("r032_grant_count", 32'(gseq.size()), 32'd10);
      for (int k = 0; k < gseq.size(); k++) begin
`ifdef MEM_ARBITER_RR_EN
         chk("r033_seq", gseq[k], (k % 2 == 0) ? 32'h1 : 32'h0);
`else
         chk("r032_seq", gseq[k], (k % 5 == 4) ? 32'h0 : 32'h1);
`endif
      end
      hold_i = 1'b0; hold_d = 1'b0;
      repeat (6) run_cycle();

      // random traffic, then drain
      rand_mode = 1'b1;
      repeat (400) run_cycle();
      rand_mode = 1'b0;
      repeat (12) run_cycle();
      for (int k = 0; k < 256; k++) chk("mem_image", env_mem[k], ref_mem[k]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
